neuron_forward_1: RTL and testbench

Serial forward-pass neuron. Accepts a stream of (previous-layer activation, weight) pairs, accumulates their fixed-point products plus a bias, and applies a piecewise-linear sigmoid. It presents the resulting axon value on a valid/ready output. It sits directly upstream of the back-propagation stage: its axon output is the activation that stage consumes to form the sigmoid derivative and the weight update.

---
 rtl/neuron_forward_1.sv | 133 +++++++++++++
 tb/tb_neuron_forward_1.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/neuron_forward_1.sv
// neuron_forward_1: serial forward-pass neuron.
// Accumulates activation*weight products plus a shifted bias, then applies a
// piecewise-linear sigmoid and presents the axon on a valid/ready output.
// Optional build macro NEURON_FWD_SAT_EN: saturate the shifted sum to W bits
// before the sigmoid (otherwise the low W bits are taken, i.e. wrap).
//
// state | meaning
// IDLE  | waiting for the first beat; loads bias and first product
// ACCUM | accumulating further beats until last or N_MAX beats
// ACT   | one cycle: shift, reduce to W bits, sigmoid into axon
// OUT   | axon presented with out_valid until the handshake
module neuron_forward_1 #(
   parameter int W     = 16,
   parameter int FRAC  = 12,
   parameter int N_MAX = 64
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         nf1_in_valid,
   output logic         nf1_in_ready,
   input  logic         nf1_in_last,
   input  logic [W-1:0] nf1_previous,
   input  logic [W-1:0] nf1_weight,
   input  logic [W-1:0] nf1_bias,
   output logic         nf1_out_valid,
   input  logic         nf1_out_ready,
   output logic [W-1:0] nf1_axon,
   output logic         nf1_len_err
);

   localparam int ACC_W = 2*W + $clog2(N_MAX);
   localparam int CW    = $clog2(N_MAX + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(N_MAX);

   localparam logic signed [ACC_W-1:0] S_MAX = ACC_W'(2**(W-1) - 1);
   localparam logic signed [ACC_W-1:0] S_MIN = -S_MAX - ACC_W'(1);
   localparam logic [W-1:0] X_MIN = {1'b1, {(W-1){1'b0}}};
   localparam logic [W-1:0] A_MAX = {1'b0, {(W-1){1'b1}}};

   // Sigmoid breakpoints and offsets in Q.FRAC
   localparam logic [W-1:0] ONE   = W'(1 << FRAC);
   localparam logic [W-1:0] T_HI  = W'(5 << FRAC);
   localparam logic [W-1:0] T_MID = W'((19 << FRAC) >> 3);
   localparam logic [W-1:0] C_HI  = W'((27 << FRAC) >> 5);
   localparam logic [W-1:0] C_MID = W'((5 << FRAC) >> 3);
   localparam logic [W-1:0] C_LO  = W'(1 << (FRAC - 1));

   typedef enum logic [1:0] {IDLE, ACCUM, ACT, OUT} state_t;

   state_t                   state, state_nx;
   logic signed [ACC_W-1:0]  acc, acc_nx;
   logic [CW-1:0]            count, count_nx;
   logic                     len_err_nx;
   logic                     accept;

   logic signed [2*W-1:0]    prev_x, wt_x, prod;
   logic signed [ACC_W-1:0]  prod_x, bias_x, sum;
   logic [W-1:0]             x, a, f, axon_nx;

   assign accept = nf1_in_valid && nf1_in_ready;
   assign prev_x = {{W{nf1_previous[W-1]}}, nf1_previous};
   assign wt_x   = {{W{nf1_weight[W-1]}}, nf1_weight};
   assign prod   = prev_x * wt_x;
   assign prod_x = {{(ACC_W-2*W){prod[2*W-1]}}, prod};
   assign bias_x = {{(ACC_W-W){nf1_bias[W-1]}}, nf1_bias} <<< FRAC;
   assign sum    = acc >>> FRAC;

   // Next-state, accumulator and length-limit decode
   always_comb begin
      state_nx   = state;
      acc_nx     = acc;
      count_nx   = count;
      len_err_nx = 1'b0;
      case (state)
         IDLE, ACCUM: begin
            if (accept) begin
               acc_nx   = (state == IDLE) ? bias_x + prod_x : acc + prod_x;
               count_nx = (state == IDLE) ? CW'(1) : count + CW'(1);
               if (nf1_in_last || count_nx == CNT_MAX) begin
                  state_nx   = ACT;
                  len_err_nx = !nf1_in_last;
               end else begin
                  state_nx = ACCUM;
               end
            end
         end
         ACT:     state_nx = OUT;
         OUT:     if (nf1_out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Reduce shifted sum to W bits and evaluate the PLAN sigmoid
   always_comb begin
`ifdef NEURON_FWD_SAT_EN
      if (sum > S_MAX)      x = A_MAX;
      else if (sum < S_MIN) x = X_MIN;
      else                  x = sum[W-1:0];
`else
      x = sum[W-1:0];
`endif
      if (x == X_MIN)       a = A_MAX;
      else if (x[W-1])      a = ~x + W'(1);
      else                  a = x;
      if (a >= T_HI)        f = ONE;
      else if (a >= T_MID)  f = (a >> 5) + C_HI;
      else if (a >= ONE)    f = (a >> 3) + C_MID;
      else                  f = (a >> 2) + C_LO;
      axon_nx = x[W-1] ? ONE - f : f;
   end

   // State, datapath and registered outputs; in_ready follows next state only
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         acc           <= '0;
         count         <= '0;
         nf1_in_ready  <= 1'b0;
         nf1_out_valid <= 1'b0;
         nf1_len_err   <= 1'b0;
         nf1_axon      <= '0;
      end else begin
         state         <= state_nx;
         acc           <= acc_nx;
         count         <= count_nx;
         nf1_in_ready  <= (state_nx == IDLE) || (state_nx == ACCUM);
         nf1_out_valid <= (state_nx == OUT);
         nf1_len_err   <= len_err_nx;
         if (state == ACT) nf1_axon <= axon_nx;
      end
   end

endmodule

// File: tb/tb_neuron_forward_1.sv
// Directed bench for neuron_forward_1 (N_MAX overridden to 4).
module tb_neuron_forward_1;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        in_last = 1'b0;
   logic [15:0] previous = '0;
   logic [15:0] weight = '0;
   logic [15:0] bias = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] axon;
   logic        len_err;

   int n_tests = 0;
   int n_fail  = 0;

   neuron_forward_1 #(.W(16), .FRAC(12), .N_MAX(4)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .nf1_in_valid  (in_valid),
      .nf1_in_ready  (in_ready),
      .nf1_in_last   (in_last),
      .nf1_previous  (previous),
      .nf1_weight    (weight),
      .nf1_bias      (bias),
      .nf1_out_valid (out_valid),
      .nf1_out_ready (out_ready),
      .nf1_axon      (axon),
      .nf1_len_err   (len_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Present one beat and return 1 ns after the edge that accepts it
   task automatic beat(input int p, input int w, input int b, input logic l);
      int k = 0;
      previous = 16'(p);
      weight   = 16'(w);
      bias     = 16'(b);
      in_last  = l;
      in_valid = 1'b1;
      while (!in_ready && k < 20) begin
         @(posedge clk); #1;
         k++;
      end
      if (k >= 20) chk("beat_wait", k, 0);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   // Wait for the result, check it, handshake, and check the return to IDLE
   task automatic take(input string tag, input int exp);
      int k = 0;
      while (!out_valid && k < 20) begin
         @(posedge clk); #1;
         k++;
      end
      if (k >= 20) chk({tag, "_wait"}, k, 0);
      chk(tag, 32'(axon), exp);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({tag, "_vld_drop"}, 32'(out_valid), 0);
      chk({tag, "_rdy_back"}, 32'(in_ready), 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", 32'(in_ready), 0);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_axon", 32'(axon), 0);
      chk("rst_len_err", 32'(len_err), 0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("idle_in_ready", 32'(in_ready), 1);

      // Single beat 1.0*1.0 and out_valid timing
      beat(4096, 4096, 0, 1'b1);
      chk("single_act_vld", 32'(out_valid), 0);
      chk("single_act_rdy", 32'(in_ready), 0);
      @(posedge clk); #1;
      chk("single_out_vld", 32'(out_valid), 1);
      take("single", 3072);

      // Sign and region coverage
      beat(4096, -4096, 0, 1'b1);
      take("neg_one", 1024);
      beat(4096, 0, 0, 1'b1);
      take("zero", 2048);
      beat(0, 0, 8192, 1'b1);
      take("bias_two", 3584);
      beat(-24576, 4096, 0, 1'b1);
      take("neg_six", 0);
      beat(2048, 4096, -1024, 1'b0);
      beat(2048, 4096, 0, 1'b1);
      take("two_beat", 2816);

      // Overflow: 4 beats of 7.0*7.0, last on the 4th
      beat(28672, 28672, 0, 1'b0);
      beat(28672, 28672, 0, 1'b0);
      beat(28672, 28672, 0, 1'b0);
      beat(28672, 28672, 0, 1'b1);
      chk("ovf_no_len_err", 32'(len_err), 0);
`ifdef NEURON_FWD_SAT_EN
      take("ovf_sat", 4096);
`else
      take("ovf_wrap", 3968);
`endif

      // Backpressure with a pending beat offered
      beat(4096, 4096, 0, 1'b1);
      @(posedge clk); #1;
      previous = 16'(8192);
      weight   = 16'(8192);
      in_last  = 1'b1;
      in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         chk("bp_vld", 32'(out_valid), 1);
         chk("bp_axon", 32'(axon), 3072);
         chk("bp_rdy", 32'(in_ready), 0);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      take("bp_release", 3072);
      beat(0, 0, 0, 1'b1);
      take("bp_no_consume", 2048);

      // Length limit: 4 beats of 1.0*0.25, no last
      beat(4096, 1024, 0, 1'b0);
      beat(4096, 1024, 0, 1'b0);
      beat(4096, 1024, 0, 1'b0);
      chk("len_err_early", 32'(len_err), 0);
      beat(4096, 1024, 0, 1'b0);
      chk("len_err_pulse", 32'(len_err), 1);
      chk("len_act_vld", 32'(out_valid), 0);
      @(posedge clk); #1;
      chk("len_err_drop", 32'(len_err), 0);
      chk("len_out_vld", 32'(out_valid), 1);
      take("len_result", 3072);
      beat(0, 0, -4096, 1'b1);
      take("len_fresh_bias", 1024);

      // Reset in the middle of ACCUM
      beat(4096, 4096, 0, 1'b0);
      beat(4096, 4096, 0, 1'b0);
      beat(4096, 4096, 0, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_vld", 32'(out_valid), 0);
      chk("mid_rst_axon", 32'(axon), 0);
      chk("mid_rst_rdy", 32'(in_ready), 0);
      chk("mid_rst_len", 32'(len_err), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      beat(4096, 0, 0, 1'b1);
      take("post_rst", 2048);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
